ssb_sync_tracker: RTL and testbench

Tracks SSB timing downstream of the PSS detector and closes the loop on it.
- Consumes the detector's N_id_2 / N_id_2_valid stream.
- Drives the detector's mode and requested_N_id_2 inputs: SEARCH until first hit, PAUSE between bursts, FIND inside a tolerance window around each expected SSB.
- Declares lock loss after a configurable number of consecutive misses.

---
 rtl/ssb_sync_tracker_if.sv | 38 +++
 rtl/ssb_sync_tracker.sv | 126 ++++++++++++
 tb/tb_ssb_sync_tracker.sv | 123 ++++++++++++
 3 files changed

// File: rtl/ssb_sync_tracker_if.sv
// ssb_sync_tracker_if: detector stream in, loop control and timing status out.
// SSB_TRACK_STATS_EN adds the detect/lost statistics counters.
interface ssb_sync_tracker_if #(
   parameter int CNT_DW = 17,
   parameter int MISS_W = 2
);
   logic              s_axis_in_tvalid;
   logic [1:0]        N_id_2_i;
   logic              N_id_2_valid_i;
   logic [1:0]        mode_o;
   logic [1:0]        requested_N_id_2_o;
   logic              locked_o;
   logic [1:0]        N_id_2_o;
   logic              ssb_start_o;
   logic              lost_o;
   logic [CNT_DW-1:0] sample_cnt_o;
   logic [MISS_W-1:0] miss_cnt_o;
`ifdef SSB_TRACK_STATS_EN
   logic [15:0]       detect_count_o;
   logic [7:0]        lost_count_o;
`endif
   modport master (
      output s_axis_in_tvalid, N_id_2_i, N_id_2_valid_i,
      input  mode_o, requested_N_id_2_o, locked_o, N_id_2_o, ssb_start_o, lost_o,
             sample_cnt_o, miss_cnt_o
`ifdef SSB_TRACK_STATS_EN
           , detect_count_o, lost_count_o
`endif
   );
   modport slave (
      input  s_axis_in_tvalid, N_id_2_i, N_id_2_valid_i,
      output mode_o, requested_N_id_2_o, locked_o, N_id_2_o, ssb_start_o, lost_o,
             sample_cnt_o, miss_cnt_o
`ifdef SSB_TRACK_STATS_EN
           , detect_count_o, lost_count_o
`endif
   );
endinterface

// File: rtl/ssb_sync_tracker.sv
// ssb_sync_tracker: SSB timing tracker steering the PSS detector through SEARCH/PAUSE/FIND.
// SSB_TRACK_STATS_EN adds saturating detection and lock-loss counters.
module ssb_sync_tracker #(
   parameter int SSB_INTERVAL    = 38400,
   parameter int TRACK_TOLERANCE = 100,
   parameter int MAX_MISSES      = 3,
   parameter int CNT_DW          = 17
) (
   input  logic               clk_i,
   input  logic               reset_i,
   ssb_sync_tracker_if.slave  bus
);
   localparam int MW = $clog2(MAX_MISSES + 1);
   localparam logic [1:0] SEARCH = 2'd0;
   localparam logic [1:0] FIND   = 2'd1;
   localparam logic [1:0] PAUSE  = 2'd2;
   localparam logic [CNT_DW-1:0] WIN_OPEN  = CNT_DW'(SSB_INTERVAL - TRACK_TOLERANCE);
   localparam logic [CNT_DW-1:0] WIN_CLOSE = CNT_DW'(SSB_INTERVAL + TRACK_TOLERANCE);
   localparam logic [CNT_DW-1:0] VIRT_ANCHOR = CNT_DW'(TRACK_TOLERANCE + 1);
   localparam logic [MW-1:0] LAST_MISS = MW'(MAX_MISSES - 1);
   logic [1:0]        state_q, state_d, nid_q, nid_d, req_q, req_d;
   logic              locked_q, locked_d, start_q, start_d, lost_q, lost_d;
   logic [CNT_DW-1:0] cnt_q, cnt_d, cnt_inc;
   logic [MW-1:0]     miss_q, miss_d;
   logic              hit;
   assign cnt_inc = cnt_q + CNT_DW'(1);
   assign hit     = bus.N_id_2_valid_i && (bus.N_id_2_i == nid_q);
   always_comb begin
      state_d  = state_q;
      nid_d    = nid_q;
      req_d    = req_q;
      locked_d = locked_q;
      start_d  = 1'b0;
      lost_d   = 1'b0;
      cnt_d    = cnt_q;
      miss_d   = miss_q;
      case (state_q)
         SEARCH: begin
            cnt_d = '0;
            if (bus.N_id_2_valid_i) begin
               nid_d    = bus.N_id_2_i;
               req_d    = bus.N_id_2_i;
               locked_d = 1'b1;
               start_d  = 1'b1;
               miss_d   = '0;
               state_d  = PAUSE;
            end
         end
         PAUSE: if (bus.s_axis_in_tvalid) begin
            cnt_d   = cnt_inc;
            state_d = (cnt_inc == WIN_OPEN) ? FIND : PAUSE;
         end
         FIND: begin
            // a matching detection takes priority over the window closing
            if (hit) begin
               start_d = 1'b1;
               cnt_d   = '0;
               miss_d  = '0;
               state_d = PAUSE;
            end else if (bus.s_axis_in_tvalid && cnt_q == WIN_CLOSE) begin
               if (miss_q == LAST_MISS) begin
                  state_d  = SEARCH;
                  locked_d = 1'b0;
                  lost_d   = 1'b1;
                  miss_d   = '0;
                  cnt_d    = '0;
               end else begin
                  miss_d  = miss_q + MW'(1);
                  cnt_d   = VIRT_ANCHOR;
                  state_d = PAUSE;
               end
            end else if (bus.s_axis_in_tvalid) begin
               cnt_d = cnt_inc;
            end
         end
         default: begin
            state_d = SEARCH;
            cnt_d   = '0;
         end
      endcase
   end
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state_q  <= SEARCH;
         nid_q    <= '0;
         req_q    <= '0;
         locked_q <= 1'b0;
         start_q  <= 1'b0;
         lost_q   <= 1'b0;
         cnt_q    <= '0;
         miss_q   <= '0;
      end else begin
         state_q  <= state_d;
         nid_q    <= nid_d;
         req_q    <= req_d;
         locked_q <= locked_d;
         start_q  <= start_d;
         lost_q   <= lost_d;
         cnt_q    <= cnt_d;
         miss_q   <= miss_d;
      end
   end
   assign bus.mode_o             = state_q;
   assign bus.requested_N_id_2_o = req_q;
   assign bus.locked_o           = locked_q;
   assign bus.N_id_2_o           = nid_q;
   assign bus.ssb_start_o        = start_q;
   assign bus.lost_o             = lost_q;
   assign bus.sample_cnt_o       = cnt_q;
   assign bus.miss_cnt_o         = miss_q;
`ifdef SSB_TRACK_STATS_EN
   logic [15:0] det_cnt_q;
   logic [7:0]  lost_cnt_q;
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         det_cnt_q  <= '0;
         lost_cnt_q <= '0;
      end else begin
         det_cnt_q  <= (start_d && !(&det_cnt_q)) ? det_cnt_q + 16'd1 : det_cnt_q;
         lost_cnt_q <= (lost_d && !(&lost_cnt_q)) ? lost_cnt_q + 8'd1 : lost_cnt_q;
      end
   end
   assign bus.detect_count_o = det_cnt_q;
   assign bus.lost_count_o   = lost_cnt_q;
`endif
endmodule

// File: tb/tb_ssb_sync_tracker.sv
// tb_ssb_sync_tracker: directed scoreboard bench for ssb_sync_tracker (INTERVAL 200, TOL 10, MISSES 2).
// Honours SSB_TRACK_STATS_EN when defined.
module tb_ssb_sync_tracker;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   applied = 0;
   int   miscompares = 0;
   typedef struct {
      string       tag;
      logic [1:0]  mode;
      logic        locked;
      logic [1:0]  nid;
      logic [1:0]  req;
      logic        start;
      logic        lost;
      logic [16:0] cnt;
      logic [1:0]  miss;
   } exp_t;
   exp_t sb[$];
   ssb_sync_tracker_if #(.CNT_DW(17), .MISS_W(2)) bus ();
   ssb_sync_tracker #(
      .SSB_INTERVAL(200), .TRACK_TOLERANCE(10), .MAX_MISSES(2), .CNT_DW(17)
   ) dut (
      .clk_i(clk), .reset_i(rst), .bus(bus.slave)
   );
   always #5 clk = ~clk;
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask
   task automatic cmp1(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      applied++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask
   task automatic push(input string tag, input int mode, input int locked, input int nid,
                       input int req, input int start, input int lost, input int cnt, input int miss);
      exp_t e;
      e.tag = tag; e.mode = 2'(mode); e.locked = 1'(locked); e.nid = 2'(nid); e.req = 2'(req);
      e.start = 1'(start); e.lost = 1'(lost); e.cnt = 17'(cnt); e.miss = 2'(miss);
      sb.push_back(e);
   endtask
   task automatic check();
      exp_t e;
      if (sb.size() == 0) begin
         applied++;
         miscompares++;
         $error("FAIL scoreboard: observed empty expected entry");
      end else begin
         e = sb.pop_front();
         cmp1({e.tag, ".mode"},   32'(bus.mode_o),             32'(e.mode));
         cmp1({e.tag, ".locked"}, 32'(bus.locked_o),           32'(e.locked));
         cmp1({e.tag, ".nid"},    32'(bus.N_id_2_o),           32'(e.nid));
         cmp1({e.tag, ".req"},    32'(bus.requested_N_id_2_o), 32'(e.req));
         cmp1({e.tag, ".start"},  32'(bus.ssb_start_o),        32'(e.start));
         cmp1({e.tag, ".lost"},   32'(bus.lost_o),             32'(e.lost));
         cmp1({e.tag, ".cnt"},    32'(bus.sample_cnt_o),       32'(e.cnt));
         cmp1({e.tag, ".miss"},   32'(bus.miss_cnt_o),         32'(e.miss));
      end
   endtask
   task automatic detect(input int id);
      bus.N_id_2_i       = 2'(id);
      bus.N_id_2_valid_i = 1'b1;
      tick();
      bus.N_id_2_valid_i = 1'b0;
   endtask
   initial begin
      bus.s_axis_in_tvalid = 1'b1;
      bus.N_id_2_i         = 2'd0;
      bus.N_id_2_valid_i   = 1'b0;
      ticks(3);
      rst = 1'b0;
      push("reset", 0, 0, 0, 0, 0, 0, 0, 0); check();
      ticks(50);
      push("idle", 0, 0, 0, 0, 0, 0, 0, 0); check();
      push("acquire", 2, 1, 1, 1, 1, 0, 0, 0); detect(1); check();
      push("pause_step", 2, 1, 1, 1, 0, 0, 1, 0); tick(); check();
      ticks(188);
      push("pre_find", 2, 1, 1, 1, 0, 0, 189, 0); check();
      push("enter_find", 1, 1, 1, 1, 0, 0, 190, 0); tick(); check();
      ticks(10);
      push("detect_200", 2, 1, 1, 1, 1, 0, 0, 0); detect(1); check();
      ticks(50);
      push("pause_ignore", 2, 1, 1, 1, 0, 0, 51, 0); detect(1); check();
      ticks(144);
      push("wrong_id", 1, 1, 1, 1, 0, 0, 196, 0); detect(2); check();
      ticks(14);
      push("miss_1", 2, 1, 1, 1, 0, 0, 11, 1); tick(); check();
      ticks(199);
      push("lost", 0, 0, 1, 1, 0, 1, 0, 0); tick(); check();
      push("lost_end", 0, 0, 1, 1, 0, 0, 0, 0); tick(); check();
      push("reacquire", 2, 1, 1, 1, 1, 0, 0, 0); detect(1); check();
      ticks(210);
      push("miss_a", 2, 1, 1, 1, 0, 0, 11, 1); tick(); check();
      ticks(199);
      push("close_hit", 2, 1, 1, 1, 1, 0, 0, 0); detect(1); check();
      ticks(195);
      push("pre_reset", 1, 1, 1, 1, 0, 0, 195, 0); check();
`ifdef SSB_TRACK_STATS_EN
      cmp1("detect_count", 32'(bus.detect_count_o), 32'd4);
      cmp1("lost_count",   32'(bus.lost_count_o),   32'd1);
`endif
      #3;
      rst = 1'b1;
      #1;
      push("async_reset", 0, 0, 0, 0, 0, 0, 0, 0); check();
`ifdef SSB_TRACK_STATS_EN
      cmp1("detect_count_rst", 32'(bus.detect_count_o), 32'd0);
      cmp1("lost_count_rst",   32'(bus.lost_count_o),   32'd0);
`endif
      tick();
      rst = 1'b0;
      ticks(5);
      push("post_reset", 0, 0, 0, 0, 0, 0, 0, 0); check();
      $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
      $finish;
   end
endmodule
